// File: rtl/riscv_m_pkg.sv
// Shared definitions for the M-extension divider: operand width, op codes and FSM encoding.
package riscv_m_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   localparam logic [3:0] OP_DIVU = 4'd4;
   localparam logic [3:0] OP_REMU = 4'd5;
   localparam logic [3:0] OP_DIV  = 4'd6;
   localparam logic [3:0] OP_REM  = 4'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
      return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake between the EX-stage stall logic and the divider.
interface seq_divider_if;
   import riscv_m_pkg::*;

   logic            start;
   logic            kill;
   logic [3:0]      op;
   logic [XLEN-1:0] in1;
   logic [XLEN-1:0] in2;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, kill, op, in1, in2,
                   input  busy, done, result);

   modport slave  (input  start, kill, op, in1, in2,
                   output busy, done, result);

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left and subtract the divisor if it fits.
module div_step
   import riscv_m_pkg::*;
(
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign trial   = shifted - {1'b0, divisor_i};

   // A clear sign bit means the divisor fit; the restored remainder always fits XLEN bits.
   always_comb begin
      if (!trial[XLEN]) begin
         rem_o = trial[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with start/done handshake and flush.
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after DONE
// CALC  | 32 restoring iterations on operand magnitudes, cnt 0..31
// FIX   | apply quotient/remainder sign, commit result
// DONE  | result committed; busy still high, start ignored
module seq_divider
   import riscv_m_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   seq_divider_if.slave bus
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   rem_q, quo_q, dvs_q, result_q;
   logic              sel_rem_q, neg_quo_q, neg_rem_q;
   logic              busy_q, done_q;

   logic              op_signed, op_legal, op_ovf, op_special;
   logic [XLEN-1:0]   special_res;
   logic [XLEN-1:0]   step_rem, step_quo, fix_quo, fix_rem, fix_res;

   assign op_legal  = (bus.op[3:2] == 2'b01);
   assign op_signed = (bus.op == OP_DIV) || (bus.op == OP_REM);
   assign op_ovf    = op_signed && (bus.in1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in2 == '1);
   assign op_special = !op_legal || (bus.in2 == '0) || op_ovf;

   always_comb begin
      special_res = '0;
      if (op_legal) begin
         if (bus.in2 == '0)
            special_res = bus.op[0] ? bus.in1 : '1;
         else if (op_ovf)
            special_res = bus.op[0] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   div_step u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   assign fix_quo = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
   assign fix_rem = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
   assign fix_res = sel_rem_q ? fix_rem : fix_quo;

   // kill overrides everything except the DONE cycle, which returns to IDLE regardless.
   always_comb begin
      state_d = state_q;
      if (bus.kill) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start) state_d = op_special ? DONE : CALC;
            CALC:    if (cnt_q == {CNT_W{1'b1}}) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.kill) begin
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  quo_q     <= magnitude(bus.in1, op_signed);
                  dvs_q     <= magnitude(bus.in2, op_signed);
                  sel_rem_q <= bus.op[0];
                  neg_quo_q <= op_signed && (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]);
                  neg_rem_q <= op_signed && bus.in1[XLEN-1];
                  if (op_special)
                     result_q <= special_res;
               end
            end
            CALC: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               cnt_q <= cnt_q + 1'b1;
            end
            FIX: begin
               if (state_d == DONE)
                  result_q <= fix_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
   import riscv_m_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   seq_divider_if dif ();

   seq_divider u_dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int signed sa;
      int signed sb;
      logic      ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         4'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd5: return (b == 0) ? a : a % b;
         4'd6: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
         4'd7: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      logic ovf;
      ovf = (op == 4'd6 || op == 4'd7) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (op < 4'd4 || op > 4'd7 || b == 0 || ovf) return 1;
      return 34;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy_at_done);
      @(negedge clk);
      dif.op = op; dif.in1 = a; dif.in2 = b; dif.start = 1'b1;
      @(posedge clk);
      #1 dif.start = 1'b0;
      lat = 0; res = 'x; busy_at_done = 1'bx;
      while (lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (dif.done) begin
            res = dif.result;
            busy_at_done = dif.busy;
            break;
         end
      end
   endtask

   task automatic check_exp(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      logic [31:0] res;
      int          lat;
      logic        bsy;
      run_op(op, a, b, res, lat, bsy);
      chk({tag, " result"}, res, exp_res);
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic check_ref(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
      check_exp(tag, op, a, b, ref_div(op, a, b), ref_lat(op, a, b));
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (dif.done) n++;
      end
   endtask

   initial begin
      logic [31:0] res, a, b;
      logic [3:0]  op;
      logic        bsy;
      int          lat, n;

      dif.start = 1'b0; dif.kill = 1'b0; dif.op = 4'd0; dif.in1 = '0; dif.in2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'b0, dif.busy}, 32'h0);
      chk("reset done", {31'b0, dif.done}, 32'h0);
      chk("reset result", dif.result, 32'h0);
      @(negedge clk) rst = 1'b0;

      // basic unsigned, with handshake shape
      run_op(4'd4, 32'd100, 32'd7, res, lat, bsy);
      chk("divu 100/7 result", res, 32'd14);
      chk("divu 100/7 latency", 32'(lat), 32'd34);
      chk("busy low at done", {31'b0, bsy}, 32'h0);
      @(posedge clk);
      #1 chk("done one-cycle pulse", {31'b0, dif.done}, 32'h0);
      check_exp("remu 100/7", 4'd5, 32'd100, 32'd7, 32'd2, 34);

      check_exp("div -7/2", 4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      check_exp("rem -7/2", 4'd7, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      check_exp("div 7/-2", 4'd6, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      check_exp("rem 7/-2", 4'd7, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

      check_exp("divu 5/0", 4'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      check_exp("rem 5/0", 4'd7, 32'd5, 32'd0, 32'd5, 1);
      check_exp("div ovf", 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      check_exp("rem ovf", 4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      check_exp("illegal op", 4'd2, 32'd50, 32'd5, 32'h0, 1);
      check_exp("divu big divisor", 4'd4, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);

      // kill mid-CALC at cnt=10
      check_exp("divu 1000/3", 4'd4, 32'd1000, 32'd3, 32'd333, 34);
      @(negedge clk);
      dif.op = 4'd6; dif.in1 = 32'hFFFF_FC18; dif.in2 = 32'd7; dif.start = 1'b1;
      @(posedge clk);
      #1 dif.start = 1'b0;
      chk("busy after accept", {31'b0, dif.busy}, 32'h1);
      repeat (10) @(posedge clk);
      #1 dif.kill = 1'b1;
      @(posedge clk);
      #1 dif.kill = 1'b0;
      chk("kill busy", {31'b0, dif.busy}, 32'h0);
      chk("kill done", {31'b0, dif.done}, 32'h0);
      chk("kill result held", dif.result, 32'd333);
      count_dones(40, n);
      chk("kill no done", 32'(n), 32'd0);
      check_exp("after kill", 4'd5, 32'd1000, 32'd7, 32'd6, 34);

      // kill together with start in IDLE drops the request
      @(negedge clk);
      dif.op = 4'd4; dif.in1 = 32'd9; dif.in2 = 32'd0; dif.start = 1'b1; dif.kill = 1'b1;
      @(posedge clk);
      #1 begin dif.start = 1'b0; dif.kill = 1'b0; end
      chk("idle kill busy", {31'b0, dif.busy}, 32'h0);
      count_dones(40, n);
      chk("idle kill no done", 32'(n), 32'd0);
      chk("idle kill result", dif.result, 32'd6);

      // kill in the DONE cycle still delivers
      @(negedge clk);
      dif.op = 4'd4; dif.in1 = 32'd81; dif.in2 = 32'd9; dif.start = 1'b1;
      @(posedge clk);
      #1 dif.start = 1'b0;
      repeat (33) @(posedge clk);
      #1 dif.kill = 1'b1;
      @(posedge clk);
      #1 dif.kill = 1'b0;
      chk("kill in DONE done", {31'b0, dif.done}, 32'h1);
      chk("kill in DONE result", dif.result, 32'd9);

      // start held high with churning operands while busy
      @(negedge clk);
      dif.op = 4'd4; dif.in1 = 32'd1000; dif.in2 = 32'd10; dif.start = 1'b1;
      @(posedge clk);
      #1;
      lat = 0; n = 0; res = 'x;
      while (lat < 60) begin
         dif.in1 = $urandom; dif.in2 = $urandom; dif.op = 4'($urandom_range(4, 7));
         @(posedge clk);
         #1;
         lat++;
         if (dif.done) begin
            n++; res = dif.result; dif.start = 1'b0;
            break;
         end
      end
      dif.start = 1'b0;
      chk("held start result", res, 32'd100);
      chk("held start latency", 32'(lat), 32'd34);
      count_dones(40, lat);
      chk("held start one done", 32'(n + lat), 32'd1);

      // asynchronous reset mid-CALC
      check_exp("divu pre-reset", 4'd4, 32'd100, 32'd7, 32'd14, 34);
      @(negedge clk);
      dif.op = 4'd5; dif.in1 = 32'd12345; dif.in2 = 32'd17; dif.start = 1'b1;
      @(posedge clk);
      #1 dif.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy", {31'b0, dif.busy}, 32'h0);
      chk("async rst done", {31'b0, dif.done}, 32'h0);
      chk("async rst result", dif.result, 32'h0);
      @(negedge clk) rst = 1'b0;
      check_ref("after reset", 4'd7, 32'hFFFF_0000, 32'd3);

      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         check_ref($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
